// File: rtl/ps2_host_port_if.sv
// ps2_host_port_if: user-side bundle of the PS/2 host port.
//   cmd_data/cmd_valid/cmd_ready : command byte handshake (user -> port)
//   tx_done/tx_err               : 1-cycle command result pulses
//   rx_data/rx_valid/rx_ready    : RX FIFO head and pop handshake
//   rx_frame_err                 : 1-cycle pulse, received frame dropped
//   rx_overflow                  : sticky, good frame lost to a full FIFO
//   busy                         : port FSM not idle
// master = keyboard/mouse decoder side, slave = the port itself.
`timescale 1ns/1ps
interface ps2_host_port_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       tx_done;
    logic       tx_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overflow;
    logic       busy;

    modport master (
        output cmd_data, cmd_valid, rx_ready,
        input  cmd_ready, tx_done, tx_err, rx_data, rx_valid,
               rx_frame_err, rx_overflow, busy
    );

    modport slave (
        input  cmd_data, cmd_valid, rx_ready,
        output cmd_ready, tx_done, tx_err, rx_data, rx_valid,
               rx_frame_err, rx_overflow, busy
    );
endinterface

// File: rtl/ps2_host_port.sv
// ps2_host_port: bidirectional PS/2 host port with glitch filter, framed
// receive into an RX FIFO, a one-entry command queue with per-phase timeout
// and optional auto-issue of an init command after reset.
//   CLOCK_50 : system clock
//   reset_n  : async active-low reset (pads released immediately)
//   PS2_CLK  : open-drain PS/2 clock pad (host drives 0 or Z)
//   PS2_DAT  : open-drain PS/2 data pad (host drives 0 or Z)
//   host     : command / result / RX FIFO bundle (ps2_host_port_if.slave)
`timescale 1ns/1ps
module ps2_host_port #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned RX_DEPTH   = 8,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter bit          INIT_EN    = 1'b0,
    parameter logic [7:0]  INIT_CMD   = 8'hF4
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    inout  wire  PS2_CLK,
    inout  wire  PS2_DAT,
    ps2_host_port_if.slave host
);
    localparam int unsigned INH_CYC   = CLK_HZ / 10_000;   // 100 us
    localparam int unsigned QUIET_CYC = CLK_HZ / 10_000;   // 100 us
    localparam int unsigned TO_CYC    = (CLK_HZ / 1000) * TIMEOUT_US / 1000;
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned IW = $clog2(INH_CYC + 1);
    localparam int unsigned QW = $clog2(QUIET_CYC + 1);
    localparam int unsigned TW = $clog2(TO_CYC + 1);
    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RX, S_INHIBIT, S_TX, S_ACK} state_t;

    // ---------------- pad filter: index 0 = clock, 1 = data ----------------
    logic [1:0]    pad_in, sync1, sync2, filt;
    logic [FW-1:0] hold [2];
    logic          fclk_d;
    logic          fclk, fdat, clk_fall, clk_rise;

    assign pad_in = {PS2_DAT, PS2_CLK};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            fclk_d <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) hold[i[0]] <= '0;
        end else begin
            sync1  <= pad_in;
            sync2  <= sync1;
            fclk_d <= filt[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i[0]] == filt[i[0]]) begin
                    hold[i[0]] <= '0;
                end else if (hold[i[0]] == FW'(FILTER_LEN - 1)) begin
                    filt[i[0]] <= sync2[i[0]];
                    hold[i[0]] <= '0;
                end else begin
                    hold[i[0]] <= hold[i[0]] + FW'(1);
                end
            end
        end
    end

    assign fclk     = filt[0];
    assign fdat     = filt[1];
    assign clk_fall = fclk_d & ~fclk;
    assign clk_rise = ~fclk_d & fclk;

    // ---------------- bus-quiet counter (filtered clock high) ---------------
    logic [QW-1:0] quiet_cnt;
    logic          quiet_ok;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)                         quiet_cnt <= '0;
        else if (!fclk)                       quiet_cnt <= '0;
        else if (quiet_cnt != QW'(QUIET_CYC)) quiet_cnt <= quiet_cnt + QW'(1);
    end
    assign quiet_ok = (quiet_cnt == QW'(QUIET_CYC));

    // ---------------- main FSM, command queue and pads ----------------------
    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    rx_shift, rx_byte;
    logic          rx_par, rx_push;
    logic [8:0]    tx_shift;
    logic          ack_seen, ack_bit;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_exp;
    logic          clk_oe, dat_oe;
    logic          pend;
    logic [7:0]    pend_data;
    logic          cmd_ready_q, tx_done_q, tx_err_q, frame_err_q;
    logic          accept;

    assign accept  = host.cmd_valid & cmd_ready_q;
    assign tmo_exp = (tmo_cnt == TW'(TO_CYC - 1));

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_byte     <= '0;
            rx_par      <= 1'b0;
            rx_push     <= 1'b0;
            tx_shift    <= '0;
            ack_seen    <= 1'b0;
            ack_bit     <= 1'b0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            clk_oe      <= 1'b0;
            dat_oe      <= 1'b0;
            pend        <= INIT_EN;
            pend_data   <= INIT_CMD;
            cmd_ready_q <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_push     <= 1'b0;

            // Result sites below override these when a command completes.
            if (accept) begin
                pend        <= 1'b1;
                pend_data   <= host.cmd_data;
                cmd_ready_q <= 1'b0;
            end else if (!pend) begin
                cmd_ready_q <= 1'b1;
            end

            if (state == S_IDLE || state == S_INHIBIT || clk_fall || clk_rise)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            case (state)
                S_IDLE: begin
                    clk_oe <= 1'b0;
                    dat_oe <= 1'b0;
                    if (clk_fall && !fdat) begin
                        state   <= S_RX;
                        bit_cnt <= '0;
                    end else if (pend && quiet_ok) begin
                        state    <= S_INHIBIT;
                        clk_oe   <= 1'b1;
                        inh_cnt  <= '0;
                        tx_shift <= {~^pend_data, pend_data};
                    end
                end
                S_RX: begin
                    if (clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8) begin
                            rx_shift <= {fdat, rx_shift[7:1]};
                        end else if (bit_cnt == 4'd8) begin
                            rx_par <= fdat;
                        end else begin
                            state <= S_IDLE;
                            if (fdat && (^{rx_shift, rx_par})) begin
                                rx_push <= 1'b1;
                                rx_byte <= rx_shift;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end else if (tmo_exp) begin
                        state       <= S_IDLE;
                        frame_err_q <= 1'b1;
                    end
                end
                S_INHIBIT: begin
                    inh_cnt <= inh_cnt + IW'(1);
                    if (inh_cnt == IW'(INH_CYC - 1)) begin
                        clk_oe  <= 1'b0;
                        dat_oe  <= 1'b1;   // start bit
                        bit_cnt <= '0;
                        state   <= S_TX;
                    end
                end
                S_TX: begin
                    if (clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd9) begin
                            dat_oe   <= ~tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[8:1]};
                        end else begin
                            dat_oe   <= 1'b0;   // stop bit slot
                            ack_seen <= 1'b0;
                            state    <= S_ACK;
                        end
                    end else if (tmo_exp) begin
                        clk_oe      <= 1'b0;
                        dat_oe      <= 1'b0;
                        tx_err_q    <= 1'b1;
                        pend        <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_ACK: begin
                    if (tmo_exp) begin
                        clk_oe      <= 1'b0;
                        dat_oe      <= 1'b0;
                        tx_err_q    <= 1'b1;
                        pend        <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end else if (!ack_seen) begin
                        if (clk_fall) begin
                            ack_bit  <= fdat;
                            ack_seen <= 1'b1;
                        end
                    end else if (fclk && fdat) begin
                        tx_done_q   <= ~ack_bit;
                        tx_err_q    <= ack_bit;
                        pend        <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

    // ---------------- RX FIFO ----------------
    logic [7:0]    mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic          full, empty, pop, push_ok;
    logic [7:0]    head_next, rx_data_q;
    logic          overflow_q;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop     = ~empty & host.rx_ready;
    assign push_ok = rx_push & (~full | pop);

    // rx_data is a register: preload the byte that will be at the head next cycle.
    always_comb begin
        rd_nxt    = rd_ptr + PW'(pop);
        head_next = mem[rd_nxt[AW-1:0]];
        if (push_ok && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) head_next = rx_byte;
    end

    always_ff @(posedge CLOCK_50) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(push_ok);
            rd_ptr    <= rd_nxt;
            rx_data_q <= head_next;
            if (rx_push && !push_ok) overflow_q <= 1'b1;
        end
    end

    assign host.cmd_ready    = cmd_ready_q;
    assign host.tx_done      = tx_done_q;
    assign host.tx_err       = tx_err_q;
    assign host.rx_data      = rx_data_q;
    assign host.rx_valid     = ~empty;
    assign host.rx_frame_err = frame_err_q;
    assign host.rx_overflow  = overflow_q;
    assign host.busy         = (state != S_IDLE);
endmodule

// File: tb/tb_ps2_host_port.sv
// tb_ps2_host_port: directed bench for ps2_host_port (INIT_EN=1, shortened
// timeout) acting as the PS/2 device on the open-drain pads.
`timescale 1ns/1ps
module tb_ps2_host_port;
    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;
    wire  PS2_CLK;
    wire  PS2_DAT;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_ferr = 0;
    bit early_ready = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    pullup (PS2_CLK);
    pullup (PS2_DAT);
    assign PS2_CLK = dev_clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_port_if bus ();

    ps2_host_port #(
        .CLK_HZ(50_000_000), .FILTER_LEN(8), .RX_DEPTH(8),
        .TIMEOUT_US(200), .INIT_EN(1'b1), .INIT_CMD(8'hF4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .host    (bus.slave)
    );

    always @(negedge CLOCK_50) begin
        if (reset_n && n_done == 0 && bus.cmd_ready && !bus.tx_done) early_ready = 1'b1;
        if (bus.tx_done)      n_done++;
        if (bus.tx_err)       n_err++;
        if (bus.rx_frame_err) n_ferr++;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dev_half();
        repeat (30) @(negedge CLOCK_50);
    endtask

    // Device-to-host frame; bad_par flips the parity bit.
    task automatic dev_send(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_dat_low = ~bits[0];
            bits = bits >> 1;
            dev_half();
            dev_clk_low = 1'b1;
            dev_half();
            dev_clk_low = 1'b0;
        end
        dev_dat_low = 1'b0;
        repeat (40) @(negedge CLOCK_50);
    endtask

    // Host-to-device: wait for inhibit, clock in 10 line bits, then ack with 0.
    task automatic dev_recv(output logic [10:0] line, output int low_cyc, output bit ok);
        int n;
        ok = 1'b1; line = '0; low_cyc = 0; n = 0;
        while (PS2_CLK !== 1'b0 && n < 40000) begin @(negedge CLOCK_50); n++; end
        if (PS2_CLK !== 1'b0) begin ok = 1'b0; return; end
        while (PS2_CLK === 1'b0 && low_cyc < 20000) begin @(negedge CLOCK_50); low_cyc++; end
        repeat (5) @(negedge CLOCK_50);
        line = {PS2_DAT, line[10:1]};
        for (int i = 1; i <= 10; i++) begin
            dev_half();
            dev_clk_low = 1'b1;
            dev_half();
            line = {PS2_DAT, line[10:1]};
            dev_clk_low = 1'b0;
        end
        dev_half();
        dev_dat_low = 1'b1;
        dev_half();
        dev_clk_low = 1'b1;
        dev_half();
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (40) @(negedge CLOCK_50);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int n;
        n = 0;
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 40000) begin @(negedge CLOCK_50); n++; end
        check("cmd_ready_wait", bus.cmd_ready, 1);
        @(negedge CLOCK_50);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [10:0] line;
        int          low_cyc;
        bit          ok;
        int          cnt;

        bus.cmd_data  = '0;
        bus.cmd_valid = 1'b0;
        bus.rx_ready  = 1'b0;

        // Reset state
        repeat (5) @(negedge CLOCK_50);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rx_valid",  bus.rx_valid, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_rx_data",   bus.rx_data, 0);
        check("rst_overflow",  bus.rx_overflow, 0);
        check("rst_pad_clk",   PS2_CLK, 1);
        check("rst_pad_dat",   PS2_DAT, 1);
        reset_n = 1'b1;

        // Init command F4 with a 1-cycle clock glitch during the quiet wait
        repeat (100) @(negedge CLOCK_50);
        dev_clk_low = 1'b1;
        @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (50) @(negedge CLOCK_50);
        check("init_glitch_busy", bus.busy, 0);
        check("init_cmd_ready", bus.cmd_ready, 0);
        dev_recv(line, low_cyc, ok);
        check("init_inhibit_seen", ok, 1);
        check("init_inhibit_len", low_cyc >= 5000, 1);
        check("init_line", line, 11'b1_0_11110100_0);
        check("init_done", n_done, 1);
        check("init_no_err", n_err, 0);
        check("init_early_ready", early_ready, 0);
        check("init_ready_after", bus.cmd_ready, 1);
        check("init_busy_after", bus.busy, 0);

        // Glitch while idle must not start a frame
        dev_clk_low = 1'b1;
        @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (50) @(negedge CLOCK_50);
        check("glitch_busy", bus.busy, 0);
        check("glitch_ferr", n_ferr, 0);

        // Test 1: good frame 0x1C
        dev_send(8'h1C, 1'b0);
        check("t1_rx_valid", bus.rx_valid, 1);
        check("t1_rx_data", bus.rx_data, 8'h1C);
        check("t1_ferr", n_ferr, 0);
        bus.rx_ready = 1'b1;
        @(negedge CLOCK_50);
        bus.rx_ready = 1'b0;
        check("t1_popped", bus.rx_valid, 0);

        // Test 2: parity error
        dev_send(8'h1C, 1'b1);
        check("t2_ferr", n_ferr, 1);
        check("t2_rx_valid", bus.rx_valid, 0);

        // Test 3: 9 frames into an 8-deep FIFO
        for (int k = 0; k < 8; k++) dev_send(8'h30 + 8'(k), 1'b0);
        check("t3_no_ovf_at_8", bus.rx_overflow, 0);
        dev_send(8'h38, 1'b0);
        check("t3_overflow", bus.rx_overflow, 1);
        bus.rx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t3_order", bus.rx_data, 8'h30 + 8'(k));
            @(negedge CLOCK_50);
        end
        bus.rx_ready = 1'b0;
        check("t3_empty", bus.rx_valid, 0);
        check("t3_ferr", n_ferr, 1);

        // Test 4: command ED, acked
        send_cmd(8'hED);
        check("t4_ready_low", bus.cmd_ready, 0);
        dev_recv(line, low_cyc, ok);
        check("t4_inhibit_seen", ok, 1);
        check("t4_inhibit_len", low_cyc >= 5000, 1);
        check("t4_line", line, 11'b1_1_11101101_0);
        check("t4_done", n_done, 2);
        check("t4_no_err", n_err, 0);

        // Test 5: command FF, device silent -> timeout
        send_cmd(8'hFF);
        cnt = 0;
        while (PS2_CLK !== 1'b0 && cnt < 40000) begin @(negedge CLOCK_50); cnt++; end
        cnt = 0;
        while (PS2_CLK !== 1'b1 && cnt < 20000) begin @(negedge CLOCK_50); cnt++; end
        cnt = 0;
        while (n_err == 0 && cnt < 30000) begin @(negedge CLOCK_50); cnt++; end
        check("t5_err", n_err, 1);
        check("t5_latency", (cnt >= 10000) && (cnt <= 10100), 1);
        repeat (2) @(negedge CLOCK_50);
        check("t5_pad_clk", PS2_CLK, 1);
        check("t5_pad_dat", PS2_DAT, 1);
        check("t5_cmd_ready", bus.cmd_ready, 1);
        check("t5_busy", bus.busy, 0);
        check("t5_done_unchanged", n_done, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
